// File: rtl/ram_port_master.sv
// Purpose: burst initiator for an 8x128 single-port RAM with shared tristate data bus and separate strobes.
// Latency: a read beat's rd_valid rises two clocks after its address is presented; a write beat hits the pins one clock after its handshake.
// Backpressure: cmd_ready only in IDLE, wr_ready only in WR (stalls freely); read data has no backpressure.
module ram_port_master #(
    parameter int AW = 7,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    inout  wire  [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_r,
    output logic          ram_w
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_FLUSH,
        S_RD,
        S_RD_DRAIN,
        S_TURN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;             // beats remaining after the current one
    logic [AW-1:0] beat_addr_q, beat_addr_d; // next write address
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_r_q, ram_r_d;
    logic          ram_w_q, ram_w_d;
    logic          drv_q, drv_d;             // master owns the data bus
    logic [DW-1:0] wdat_q, wdat_d;
    logic          rd_first_q, rd_first_d;   // first RD cycle: bus still holds a stale word
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          capture;

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WR);
    assign busy      = (state_q != S_IDLE);
    assign ram_addr  = ram_addr_q;
    assign ram_r     = ram_r_q;
    assign ram_w     = ram_w_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign ram_data  = drv_q ? wdat_q : {DW{1'bz}};

    // Next-state and registered-output decode; strobes and bus drive default to released.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_addr_d = beat_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_r_d     = 1'b0;
        ram_w_d     = 1'b0;
        drv_d       = 1'b0;
        wdat_d      = wdat_q;
        rd_first_d  = rd_first_q;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d = cmd_len;
                    if (cmd_we) begin
                        state_d     = S_WR;
                        beat_addr_d = cmd_addr;
                    end else begin
                        state_d    = S_RD;
                        ram_r_d    = 1'b1;
                        ram_addr_d = cmd_addr;
                        rd_first_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                if (wr_valid) begin
                    ram_w_d     = 1'b1;
                    drv_d       = 1'b1;
                    wdat_d      = wr_data;
                    ram_addr_d  = beat_addr_q;
                    beat_addr_d = beat_addr_q + AW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_WR_FLUSH;
                    end else begin
                        cnt_d = cnt_q - AW'(1);
                    end
                end
            end
            S_WR_FLUSH: begin
                state_d = S_TURN;
            end
            S_RD: begin
                ram_r_d    = 1'b1;
                rd_first_d = 1'b0;
                capture    = !rd_first_q;
                if (cnt_q == '0) begin
                    // Address holds; the extra read of the last word is discarded.
                    state_d = S_RD_DRAIN;
                end else begin
                    cnt_d      = cnt_q - AW'(1);
                    ram_addr_d = ram_addr_q + AW'(1);
                end
            end
            S_RD_DRAIN: begin
                capture = 1'b1;
                state_d = S_TURN;
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_valid_d = capture;
        rd_data_d  = capture ? ram_data : rd_data_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            beat_addr_q <= '0;
            ram_addr_q  <= '0;
            ram_r_q     <= 1'b0;
            ram_w_q     <= 1'b0;
            drv_q       <= 1'b0;
            wdat_q      <= '0;
            rd_first_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_addr_q <= beat_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_r_q     <= ram_r_d;
            ram_w_q     <= ram_w_d;
            drv_q       <= drv_d;
            wdat_q      <= wdat_d;
            rd_first_q  <= rd_first_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

endmodule
